// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, with a
// start/done handshake. Divide-by-zero completes immediately with q = all ones.
module seq_div #(
  parameter int unsigned N = 8,  // dividend / quotient width, N >= 2
  parameter int unsigned M = 4   // divisor / remainder width, M <= N
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [M-1:0] b,
  output logic [N-1:0] q,
  output logic [M-1:0] r,
  output logic         busy,
  output logic         done,
  output logic         div0
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LastStep = CW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    d_q, d_d;      // dividend shifts out, quotient shifts in
  logic [M-1:0]    b_q, b_d;
  logic [M:0]      p_q, p_d;      // partial remainder, one guard bit
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    q_q, q_d;
  logic [M-1:0]    r_q, r_d;
  logic            div0_q, div0_d;

  logic [M:0]      p_shift;
  logic [M:0]      p_sub;
  logic            qbit;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StIdle;
      d_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      div0_q  <= div0_d;
    end
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    b_d     = b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    div0_d  = div0_q;

    // P stays below B, so the shifted value fits in M+1 bits.
    p_shift = {p_q[M-1:0], d_q[N-1]};
    p_sub   = p_shift - {1'b0, b_q};
    qbit    = (p_shift >= {1'b0, b_q});

    case (state_q)
      StIdle: begin
        if (start) begin
          d_d   = a;
          b_d   = b;
          p_d   = '0;
          cnt_d = '0;
          if (b == '0) begin
            q_d     = '1;
            r_d     = '0;
            div0_d  = 1'b1;
            state_d = StDone;
          end else begin
            div0_d  = 1'b0;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        p_d   = qbit ? p_sub : p_shift;
        d_d   = {d_q[N-2:0], qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastStep) begin
          q_d     = d_d;
          r_d     = p_d[M-1:0];
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign q    = q_q;
  assign r    = r_q;
  assign div0 = div0_q;
  assign busy = (state_q == StCalc);
  assign done = (state_q == StDone);

endmodule
